// File: rtl/tpu_pkg.sv
// Shared types and sizing helpers for the systolic datapath feeders.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    LOADED = 2'd2,
    STREAM = 2'd3
  } ldr_state_t;

  // A skewed tile drains in 2*DIM-1 cycles: the last lane starts DIM-1 cycles late.
  function automatic int stream_len(input int dim);
    return 2 * dim - 1;
  endfunction

  function automatic int step_cnt_w(input int dim);
    return $clog2(2 * dim);
  endfunction

endpackage

// File: rtl/memb_skew_loader.sv
// Collects a DIM x DIM B tile one row per handshake, then streams it diagonally
// skewed (lane i delayed i cycles, zero outside its window) into the B FIFO bank.
module memb_skew_loader
  import tpu_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [BITS_AB-1:0] in_row [DIM-1:0],
  input  logic                      start,
  output logic                      busy,
  output logic                      loaded,
  output logic                      done,
  output logic                      en_out,
  output logic signed [BITS_AB-1:0] Bout [DIM-1:0]
);

  localparam int LEN = stream_len(DIM);
  localparam int CW  = step_cnt_w(DIM);
  localparam int RW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int RCW = $clog2(DIM + 1);

  ldr_state_t state, state_nxt;
  logic [RCW-1:0] row_cnt, row_cnt_nxt;
  logic [CW-1:0]  step, step_nxt;
  logic           done_nxt;
  logic           en_nxt;
  logic           accept;

  logic signed [BITS_AB-1:0] tile     [DIM-1:0][DIM-1:0];
  logic signed [BITS_AB-1:0] lane_nxt [DIM-1:0];

  assign in_ready = ((state == IDLE) || (state == FILL)) && (row_cnt < RCW'(DIM));
  assign loaded   = (state == LOADED);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    step_nxt    = step;
    done_nxt    = 1'b0;
    case (state)
      IDLE, FILL: begin
        if (accept) begin
          row_cnt_nxt = row_cnt + 1'b1;
          state_nxt   = (row_cnt == RCW'(DIM - 1)) ? LOADED : FILL;
        end
      end
      LOADED: begin
        if (start) begin
          state_nxt = STREAM;
          step_nxt  = '0;
        end
      end
      STREAM: begin
        if (step == CW'(LEN - 1)) begin
          state_nxt   = IDLE;
          row_cnt_nxt = '0;
          step_nxt    = '0;
          done_nxt    = 1'b1;
        end else begin
          step_nxt = step + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    en_nxt = (state_nxt == STREAM);
  end

  // Lane data is looked up for the upcoming step so Bout leaves a register.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic [CW-1:0] rel;
    logic [RW-1:0] row_idx;
    always_comb begin
      rel         = step_nxt - CW'(i);
      row_idx     = rel[RW-1:0];
      lane_nxt[i] = '0;
      if (en_nxt && (step_nxt >= CW'(i)) && (rel < CW'(DIM))) begin
        lane_nxt[i] = tile[row_idx][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row_cnt <= '0;
      step    <= '0;
      en_out  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < DIM; i++) Bout[i] <= '0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
      step    <= step_nxt;
      en_out  <= en_nxt;
      busy    <= en_nxt;
      done    <= done_nxt;
      for (int i = 0; i < DIM; i++) Bout[i] <= lane_nxt[i];
    end
  end

  // Storage is deliberately left uncleared by reset; row_cnt alone tracks validity.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      tile[RW'(row_cnt)] <= in_row;
    end
  end

endmodule

// File: tb/tb_memb_skew_loader.sv
// Randomised bench for memb_skew_loader against a cycle-level behavioural model.
module tb_memb_skew_loader;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;
  localparam int LEN     = 2 * DIM - 1;
  localparam int NSC     = 7;

  logic clk = 1'b0;
  logic rst, in_valid, start;
  logic in_ready, busy, loaded, done, en_out;
  logic signed [BITS_AB-1:0] in_row [DIM-1:0];
  logic signed [BITS_AB-1:0] bout   [DIM-1:0];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 = accepting rows, 1 = full tile waiting, 2 = streaming step m_t.
  int m_phase, m_rows, m_t;
  bit m_done;
  int m_tile [DIM][DIM];
  int en_run = 0;

  // Scenario knobs. valid: 0 always, 1 every 3rd cycle, 2 random, 3 never.
  // pattern: 0 random, 1 r*8+j, 2 -128/127 alternating. start: 0 random pulse, 1 held, 2 never.
  int sc_cyc   [NSC] = '{10, 60, 50, 90, 90, 70, 400};
  int sc_val   [NSC] = '{3,  0,  0,  1,  1,  0,  2};
  int sc_pat   [NSC] = '{0,  1,  2,  0,  0,  0,  0};
  int sc_start [NSC] = '{2,  0,  0,  0,  1,  1,  0};
  int sc_rst   [NSC] = '{-1, -1, -1, -1, -1, 6, -1};

  always #5 clk = ~clk;

  memb_skew_loader #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .start    (start),
    .busy     (busy),
    .loaded   (loaded),
    .done     (done),
    .en_out   (en_out),
    .Bout     (bout)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int exp;
    check("in_ready", int'(in_ready), (m_phase == 0 && m_rows < DIM) ? 1 : 0);
    check("loaded",   int'(loaded),   (m_phase == 1) ? 1 : 0);
    check("busy",     int'(busy),     (m_phase == 2) ? 1 : 0);
    check("en_out",   int'(en_out),   (m_phase == 2) ? 1 : 0);
    check("done",     int'(done),     m_done ? 1 : 0);
    for (int i = 0; i < DIM; i++) begin
      exp = 0;
      if (m_phase == 2 && m_t >= i && m_t - i < DIM) exp = m_tile[m_t - i][i];
      check($sformatf("bout%0d", i), int'(bout[i]), exp);
    end
    if (en_out === 1'b1) begin
      en_run++;
    end else begin
      if (done === 1'b1) check("stream_len", en_run, LEN);
      en_run = 0;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_phase = 0;
      m_rows  = 0;
      m_t     = 0;
      m_done  = 1'b0;
      return;
    end
    m_done = 1'b0;
    case (m_phase)
      0: if (in_valid && m_rows < DIM) begin
           for (int j = 0; j < DIM; j++) m_tile[m_rows][j] = int'(in_row[j]);
           m_rows++;
           if (m_rows == DIM) m_phase = 1;
         end
      1: if (start) begin
           m_phase = 2;
           m_t     = 0;
         end
      default: if (m_t == LEN - 1) begin
           m_phase = 0;
           m_rows  = 0;
           m_done  = 1'b1;
         end else begin
           m_t++;
         end
    endcase
  endtask

  task automatic drive(input int s, input int c, inout bit rst_used);
    int r;
    rst = 1'b0;
    if (sc_rst[s] >= 0 && !rst_used && m_phase == 2 && m_t == sc_rst[s]) begin
      rst      = 1'b1;
      rst_used = 1'b1;
    end
    case (sc_val[s])
      0:       in_valid = 1'b1;
      1:       in_valid = (c % 3 == 0);
      2:       in_valid = ($urandom_range(0, 1) == 1);
      default: in_valid = 1'b0;
    endcase
    case (sc_start[s])
      0:       start = ($urandom_range(0, 3) == 0);
      1:       start = 1'b1;
      default: start = 1'b0;
    endcase
    r = m_rows;
    for (int j = 0; j < DIM; j++) begin
      case (sc_pat[s])
        1:       in_row[j] = BITS_AB'(r * 8 + j);
        2:       in_row[j] = ((r + j) % 2 == 0) ? -8'sd128 : 8'sd127;
        default: in_row[j] = BITS_AB'($urandom_range(0, 255));
      endcase
    end
  endtask

  initial begin
    bit rst_used;
    rst      = 1'b1;
    in_valid = 1'b0;
    start    = 1'b0;
    for (int j = 0; j < DIM; j++) in_row[j] = '0;
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++) m_tile[r][j] = 0;
    m_phase = 0;
    m_rows  = 0;
    m_t     = 0;
    m_done  = 1'b0;
    repeat (2) @(posedge clk);
    for (int s = 0; s < NSC; s++) begin
      rst_used = 1'b0;
      for (int c = 0; c < sc_cyc[s]; c++) begin
        @(negedge clk);
        check_outputs();
        drive(s, c, rst_used);
        @(posedge clk);
        model_update();
      end
    end
    @(negedge clk);
    check_outputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
